multdiv_sequencer: RTL and testbench



---
 rtl/multdiv_sequencer_if.sv | 38 +++
 rtl/multdiv_sequencer.sv | 116 +++++++++++
 tb/tb_multdiv_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the execute-stage issue logic and the multiply/divide sequencer.
//   ctrl_mult, ctrl_div : one-cycle start requests (issue side drives)
//   divisor_zero        : divisor operand is zero, qualifies a divide start
//   load_operands       : datapath captures operands, clears accumulator
//   step_en             : datapath performs one iteration
//   op_is_div           : latched operation type, 1 = divide
//   count               : current iteration index
//   result_rdy          : result or exception valid this cycle
//   exception           : divide-by-zero, meaningful only with result_rdy
//   busy                : operation in progress (LOAD, RUN or DONE)
//   stall               : freeze request to the upstream stage
interface multdiv_sequencer_if #(
  parameter int unsigned CNT_W = 6
);
  logic             ctrl_mult;
  logic             ctrl_div;
  logic             divisor_zero;
  logic             load_operands;
  logic             step_en;
  logic             op_is_div;
  logic [CNT_W-1:0] count;
  logic             result_rdy;
  logic             exception;
  logic             busy;
  logic             stall;

  // Issue side: requests operations, observes the sequencer.
  modport master (
    output ctrl_mult, ctrl_div, divisor_zero,
    input  load_operands, step_en, op_is_div, count, result_rdy, exception, busy, stall
  );

  // Sequencer side.
  modport slave (
    input  ctrl_mult, ctrl_div, divisor_zero,
    output load_operands, step_en, op_is_div, count, result_rdy, exception, busy, stall
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Control sequencer for the iterative multiply/divide unit.
// Accepts a one-cycle multiply/divide start, meters the datapath step enable with a cycle
// counter, and produces operand-load, result-ready and divide-by-zero strobes while holding
// the pipeline stall for the whole operation.
// Ports:
//   i_clk    : rising-edge clock
//   i_reset  : synchronous active-low reset
//   io_bus   : multdiv_sequencer_if.slave handshake bundle (see interface header)
module multdiv_sequencer #(
  parameter int unsigned MULT_STEPS = 32,
  parameter int unsigned DIV_STEPS  = 32,
  parameter int unsigned CNT_W      = 6
) (
  input logic                i_clk,
  input logic                i_reset,
  multdiv_sequencer_if.slave io_bus
);

  // Step limits stored as the index of the last step so N = 2^CNT_W still fits.
  localparam logic [CNT_W-1:0] MultLast = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DivLast  = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  state_e           r_state,     w_state_d;
  logic [CNT_W-1:0] r_count,     w_count_d;
  logic [CNT_W-1:0] r_last,      w_last_d;
  logic             r_op_is_div, w_op_is_div_d;
  logic             r_exc,       w_exc_d;

  logic w_start;
  logic w_accept;
  logic w_take_div;

  assign w_start    = io_bus.ctrl_mult | io_bus.ctrl_div;
  // Starts are only taken in IDLE/DONE and never in a reset cycle.
  assign w_accept   = w_start & i_reset & ((r_state == StIdle) | (r_state == StDone));
  // Multiply wins when both requests arrive together.
  assign w_take_div = ~io_bus.ctrl_mult;

  always_comb begin
    w_state_d     = r_state;
    w_count_d     = r_count;
    w_last_d      = r_last;
    w_op_is_div_d = r_op_is_div;
    w_exc_d       = r_exc;

    unique case (r_state)
      StIdle, StDone: begin
        if (r_state == StDone) begin
          w_state_d     = StIdle;
          w_count_d     = '0;
          w_op_is_div_d = 1'b0;
          w_exc_d       = 1'b0;
        end
        if (w_accept) begin
          w_op_is_div_d = w_take_div;
          w_count_d     = '0;
          if (w_take_div && io_bus.divisor_zero) begin
            // Divide by zero skips the datapath entirely.
            w_state_d = StDone;
            w_exc_d   = 1'b1;
          end else begin
            w_state_d = StLoad;
            w_exc_d   = 1'b0;
            w_last_d  = w_take_div ? DivLast : MultLast;
          end
        end
      end
      StLoad: begin
        w_state_d = StRun;
        w_count_d = '0;
      end
      StRun: begin
        if (r_count == r_last) begin
          w_state_d = StDone;
        end else begin
          w_count_d = r_count + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_last      <= '0;
      r_op_is_div <= 1'b0;
      r_exc       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_count     <= w_count_d;
      r_last      <= w_last_d;
      r_op_is_div <= w_op_is_div_d;
      r_exc       <= w_exc_d;
    end
  end

  assign io_bus.load_operands = (r_state == StLoad);
  assign io_bus.step_en       = (r_state == StRun);
  assign io_bus.result_rdy    = (r_state == StDone);
  assign io_bus.exception     = (r_state == StDone) & r_exc;
  assign io_bus.busy          = (r_state != StIdle);
  assign io_bus.op_is_div     = r_op_is_div;
  assign io_bus.count         = r_count;
  // DONE without a new start drops stall so the result can write back.
  assign io_bus.stall         = (r_state == StLoad) | (r_state == StRun) | w_accept;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer. Two instances share clock, reset and stimulus:
// A uses the default 32/32 step counts, B uses MULT_STEPS = 1, DIV_STEPS = 64.
module tb_multdiv_sequencer;

  logic clk;
  logic rst_n;
  logic tb_mult;
  logic tb_div;
  logic tb_dz;

  int n_checks;
  int n_errors;

  multdiv_sequencer_if #(.CNT_W(6)) u_if_a ();
  multdiv_sequencer_if #(.CNT_W(6)) u_if_b ();

  assign u_if_a.ctrl_mult    = tb_mult;
  assign u_if_a.ctrl_div     = tb_div;
  assign u_if_a.divisor_zero = tb_dz;
  assign u_if_b.ctrl_mult    = tb_mult;
  assign u_if_b.ctrl_div     = tb_div;
  assign u_if_b.divisor_zero = tb_dz;

  multdiv_sequencer #(
    .MULT_STEPS(32),
    .DIV_STEPS (32),
    .CNT_W     (6)
  ) u_dut_a (
    .i_clk  (clk),
    .i_reset(rst_n),
    .io_bus (u_if_a)
  );

  multdiv_sequencer #(
    .MULT_STEPS(1),
    .DIV_STEPS (64),
    .CNT_W     (6)
  ) u_dut_b (
    .i_clk  (clk),
    .i_reset(rst_n),
    .io_bus (u_if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output bundle order: {load_operands, step_en, result_rdy, exception, busy, stall}
  function automatic logic [5:0] obs_a();
    return {u_if_a.load_operands, u_if_a.step_en, u_if_a.result_rdy, u_if_a.exception,
            u_if_a.busy, u_if_a.stall};
  endfunction

  function automatic logic [5:0] obs_b();
    return {u_if_b.load_operands, u_if_b.step_en, u_if_b.result_rdy, u_if_b.exception,
            u_if_b.busy, u_if_b.stall};
  endfunction

  task automatic set_in(input logic m, input logic d, input logic z);
    tb_mult = m;
    tb_div  = d;
    tb_dz   = z;
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    step_clk();
    step_clk();
    for (int c = 0; c < 8; c++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      n_checks++;
      if (obs_a() !== 6'b0 || obs_b() !== 6'b0) begin
        n_errors++;
        $display("FAIL reset_outputs cyc=%0d got a=%b b=%b exp 000000", c, obs_a(), obs_b());
      end
      n_checks++;
      if (u_if_a.count !== 6'd0 || u_if_a.op_is_div !== 1'b0 || u_if_b.count !== 6'd0) begin
        n_errors++;
        $display("FAIL reset_state cyc=%0d got cnt=%0d div=%b exp cnt=0 div=0", c,
                 u_if_a.count, u_if_a.op_is_div);
      end
      step_clk();
    end
    idle(2);
  endtask

  task automatic test_mult();
    logic [5:0] ev;
    logic [5:0] ec;
    idle(80);
    for (int c = 0; c < 40; c++) begin
      set_in(c == 0, 1'b0, 1'b0);
      #1;
      ev = {c == 1, c >= 2 && c <= 33, c == 34, 1'b0, c >= 1 && c <= 34, c <= 33};
      ec = (c >= 2 && c <= 33) ? 6'(c - 2) : ((c == 34) ? 6'd31 : 6'd0);
      n_checks++;
      if (obs_a() !== ev) begin
        n_errors++;
        $display("FAIL mult_strobes cyc=%0d got=%b exp=%b", c, obs_a(), ev);
      end
      n_checks++;
      if (u_if_a.count !== ec || u_if_a.op_is_div !== 1'b0) begin
        n_errors++;
        $display("FAIL mult_count cyc=%0d got cnt=%0d div=%b exp cnt=%0d div=0", c,
                 u_if_a.count, u_if_a.op_is_div, ec);
      end
      step_clk();
    end
  endtask

  task automatic test_div_zero();
    logic [5:0] ev;
    idle(80);
    for (int c = 0; c < 6; c++) begin
      set_in(1'b0, c == 0, c == 0);
      #1;
      ev = {1'b0, 1'b0, c == 1, c == 1, c == 1, c == 0};
      n_checks++;
      if (obs_a() !== ev || obs_b() !== ev) begin
        n_errors++;
        $display("FAIL div_zero cyc=%0d got a=%b b=%b exp=%b", c, obs_a(), obs_b(), ev);
      end
      step_clk();
    end
  endtask

  task automatic test_both();
    int steps;
    int loads;
    int rdy_at;
    steps  = 0;
    loads  = 0;
    rdy_at = -1;
    idle(80);
    for (int c = 0; c < 40; c++) begin
      // Both requests with divisor_zero set: multiply must win, no exception.
      set_in(c == 0, c == 0 || c == 10, c == 0 || c == 10);
      #1;
      if (c == 1 || c == 20) begin
        n_checks++;
        if (u_if_a.op_is_div !== 1'b0) begin
          n_errors++;
          $display("FAIL both_op_is_div cyc=%0d got=%b exp=0", c, u_if_a.op_is_div);
        end
      end
      if (u_if_a.step_en === 1'b1) steps++;
      if (u_if_a.load_operands === 1'b1) loads++;
      if (u_if_a.result_rdy === 1'b1 && rdy_at < 0) begin
        rdy_at = c;
        n_checks++;
        if (u_if_a.exception !== 1'b0) begin
          n_errors++;
          $display("FAIL both_exception cyc=%0d got=%b exp=0", c, u_if_a.exception);
        end
      end
      step_clk();
    end
    n_checks++;
    if (steps != 32 || loads != 1 || rdy_at != 34) begin
      n_errors++;
      $display("FAIL ignore_in_run got steps=%0d loads=%0d rdy_at=%0d exp 32 1 34",
               steps, loads, rdy_at);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ev;
    logic [5:0] ec;
    logic       ed;
    idle(80);
    for (int c = 0; c < 75; c++) begin
      set_in(c == 0, c == 34, 1'b0);
      #1;
      ev = {c == 1 || c == 35, (c >= 2 && c <= 33) || (c >= 36 && c <= 67),
            c == 34 || c == 68, 1'b0, c >= 1 && c <= 68, c <= 67};
      ec = (c >= 36 && c <= 67) ? 6'(c - 36) : ((c == 68) ? 6'd31 : 6'd0);
      ed = (c >= 35 && c <= 68);
      n_checks++;
      if (obs_a() !== ev) begin
        n_errors++;
        $display("FAIL b2b_strobes cyc=%0d got=%b exp=%b", c, obs_a(), ev);
      end
      if (c >= 35) begin
        n_checks++;
        if (u_if_a.count !== ec || u_if_a.op_is_div !== ed) begin
          n_errors++;
          $display("FAIL b2b_div cyc=%0d got cnt=%0d div=%b exp cnt=%0d div=%b", c,
                   u_if_a.count, u_if_a.op_is_div, ec, ed);
        end
      end
      step_clk();
    end
  endtask

  task automatic test_reset_mid();
    idle(80);
    for (int c = 0; c < 60; c++) begin
      rst_n = (c != 19);
      set_in(c == 0 || c == 19, 1'b0, 1'b0);
      #1;
      if (c == 19) begin
        n_checks++;
        if (u_if_a.step_en !== 1'b1 || u_if_a.count !== 6'd17) begin
          n_errors++;
          $display("FAIL mid_run_count got step=%b cnt=%0d exp step=1 cnt=17",
                   u_if_a.step_en, u_if_a.count);
        end
      end
      if (c >= 20) begin
        n_checks++;
        if (obs_a() !== 6'b0 || u_if_a.count !== 6'd0 || u_if_a.op_is_div !== 1'b0) begin
          n_errors++;
          $display("FAIL after_reset cyc=%0d got=%b cnt=%0d div=%b exp 000000 cnt=0 div=0",
                   c, obs_a(), u_if_a.count, u_if_a.op_is_div);
        end
      end
      step_clk();
    end
    rst_n = 1'b1;
    test_mult();
  endtask

  task automatic test_params();
    logic [5:0] ev;
    idle(80);
    for (int c = 0; c < 6; c++) begin
      set_in(c == 0, 1'b0, 1'b0);
      #1;
      ev = {c == 1, c == 2, c == 3, 1'b0, c >= 1 && c <= 3, c <= 2};
      n_checks++;
      if (obs_b() !== ev || u_if_b.count !== 6'd0) begin
        n_errors++;
        $display("FAIL mult1 cyc=%0d got=%b cnt=%0d exp=%b cnt=0", c, obs_b(), u_if_b.count, ev);
      end
      step_clk();
    end
    idle(80);
    for (int c = 0; c < 70; c++) begin
      set_in(1'b0, c == 0, 1'b0);
      #1;
      ev = {c == 1, c >= 2 && c <= 65, c == 66, 1'b0, c >= 1 && c <= 66, c <= 65};
      n_checks++;
      if (obs_b() !== ev) begin
        n_errors++;
        $display("FAIL div64_strobes cyc=%0d got=%b exp=%b", c, obs_b(), ev);
      end
      if (c >= 2 && c <= 66) begin
        n_checks++;
        if (u_if_b.count !== ((c == 66) ? 6'd63 : 6'(c - 2)) || u_if_b.op_is_div !== 1'b1) begin
          n_errors++;
          $display("FAIL div64_count cyc=%0d got cnt=%0d div=%b exp cnt=%0d div=1", c,
                   u_if_b.count, u_if_b.op_is_div, (c == 66) ? 63 : c - 2);
        end
      end
      step_clk();
    end
  endtask

  // Timeline model: each accepted operation is an offset counter since acceptance; outputs
  // follow from the documented cycle positions of LOAD, RUN and DONE.
  task automatic test_random();
    int         mult_n [2];
    int         div_n  [2];
    bit         act    [2];
    int         pos    [2];
    int         n      [2];
    bit         zr     [2];
    bit         dv     [2];
    int         e;
    bit         acc;
    bit         m;
    bit         d;
    bit         z;
    bit         rv;
    logic [5:0] ev;
    logic [5:0] ov;
    logic [5:0] oc;
    logic [5:0] ec;
    logic       od;
    mult_n = '{32, 1};
    div_n  = '{32, 64};
    act    = '{0, 0};
    pos    = '{0, 0};
    n      = '{0, 0};
    zr     = '{0, 0};
    dv     = '{0, 0};
    idle(80);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m  = ($urandom_range(0, 7) == 0);
      d  = ($urandom_range(0, 7) == 0);
      z  = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 299) != 0);
      rst_n = rv;
      set_in(m, d, z);
      #1;
      for (int k = 0; k < 2; k++) begin
        e   = zr[k] ? 1 : n[k] + 2;
        acc = (m || d) && rv && (!act[k] || pos[k] == e);
        ev  = {act[k] && !zr[k] && pos[k] == 1,
               act[k] && !zr[k] && pos[k] >= 2 && pos[k] <= n[k] + 1,
               act[k] && pos[k] == e,
               act[k] && zr[k] && pos[k] == e,
               act[k],
               (act[k] && pos[k] < e) || acc};
        if (act[k] && !zr[k] && pos[k] >= 2 && pos[k] <= n[k] + 1) ec = 6'(pos[k] - 2);
        else if (act[k] && !zr[k] && pos[k] == e)                   ec = 6'(n[k] - 1);
        else                                                        ec = 6'd0;
        ov = (k == 0) ? obs_a() : obs_b();
        oc = (k == 0) ? u_if_a.count : u_if_b.count;
        od = (k == 0) ? u_if_a.op_is_div : u_if_b.op_is_div;
        n_checks++;
        if (ov !== ev) begin
          n_errors++;
          $display("FAIL rand_strobes dut=%0d cyc=%0d got=%b exp=%b", k, cyc, ov, ev);
        end
        if (!(act[k] && pos[k] == 1)) begin
          n_checks++;
          if (oc !== ec) begin
            n_errors++;
            $display("FAIL rand_count dut=%0d cyc=%0d got=%0d exp=%0d", k, cyc, oc, ec);
          end
        end
        if (!act[k] || !zr[k]) begin
          n_checks++;
          if (od !== (act[k] ? dv[k] : 1'b0)) begin
            n_errors++;
            $display("FAIL rand_op_is_div dut=%0d cyc=%0d got=%b exp=%b", k, cyc, od,
                     act[k] ? dv[k] : 1'b0);
          end
        end
        if (!rv) begin
          act[k] = 1'b0;
        end else if (acc) begin
          act[k] = 1'b1;
          pos[k] = 1;
          dv[k]  = !m;
          zr[k]  = !m && z;
          n[k]   = (!m) ? div_n[k] : mult_n[k];
        end else if (act[k]) begin
          if (pos[k] == e) act[k] = 1'b0;
          else             pos[k] = pos[k] + 1;
        end
      end
      step_clk();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    step_clk();
    test_reset();
    test_mult();
    test_div_zero();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_params();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
